// File: rtl/proc_mem_pkg.sv
// Shared definitions for the processor memory responder.
//   DATA_W        : processor bus data width
//   REG_*         : addr[15:12] codes of the mapped regions
//   region_t      : decoded region, produced by decode_region()
package proc_mem_pkg;

  localparam int DATA_W = 16;

  localparam logic [3:0] REG_RAM = 4'h0;
  localparam logic [3:0] REG_LED = 4'h1;
  localparam logic [3:0] REG_SW  = 4'h3;

  typedef enum logic [1:0] {
    RG_RAM  = 2'd0,
    RG_LED  = 2'd1,
    RG_SW   = 2'd2,
    RG_NONE = 2'd3
  } region_t;

  // Map the top address nibble to a region; every unlisted code is unmapped.
  function automatic region_t decode_region(input logic [3:0] code);
    region_t r;
    case (code)
      REG_RAM: r = RG_RAM;
      REG_LED: r = RG_LED;
      REG_SW:  r = RG_SW;
      default: r = RG_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sync_ram_wf.sv
// Single-port, write-first RAM with a registered read port.
// Ports:
//   clock : rising-edge clock
//   rd_en : when high the output register is updated this edge; when low it holds
//   we    : write strobe
//   addr  : word address (ADDR_W bits)
//   wdata : write data
//   rdata : registered read data (write-first: a write returns the new data)
// Contents are never reset.
module sync_ram_wf
  import proc_mem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              rd_en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (rd_en) begin
      rdata <= we ? wdata : mem[addr];
    end
  end

endmodule

// File: rtl/proc_mem_responder.sv
// Responder side of the processor memory interface: on-chip RAM, an LED
// register, a two-flop switch synchronizer and a bootload write port.
// Ports:
//   clock, resetn          : system clock, asynchronous active-low reset
//   addr, dout, wren       : processor request (word address, write data, write strobe)
//   din, rd_valid          : registered read data and its one-cycle valid
//   sw                     : raw asynchronous switches
//   ledr                   : LED register
//   load_en/addr/data      : bootload RAM write, has priority over the processor
//   wr_conflict            : pulse when a processor write was dropped by bootload
//
// Timing contract (no handshake): every request sampled at edge N with
// load_en=0 is answered in cycle N+1 with rd_valid=1 and din holding the
// result. A cycle with load_en=1 is a stall: din holds, rd_valid=0 next cycle.
module proc_mem_responder
  import proc_mem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int LED_W  = 10,
  parameter int SW_W   = 10
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [15:0]       addr,
  input  logic [15:0]       dout,
  input  logic              wren,
  output logic [15:0]       din,
  output logic              rd_valid,
  input  logic [SW_W-1:0]   sw,
  output logic [LED_W-1:0]  ledr,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [15:0]       load_data,
  output logic              wr_conflict
);

  logic [SW_W-1:0]   sw_sync1;
  logic [SW_W-1:0]   sw_sync2;
  region_t           region;
  region_t           src_q;
  logic [DATA_W-1:0] aux_next;
  logic [DATA_W-1:0] aux_q;
  logic [DATA_W-1:0] ram_q;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              led_we;

  // Bits between the RAM index and the region nibble only alias the RAM.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[11:ADDR_W];

  always_comb begin
    region    = decode_region(addr[15:12]);
    // Bootload owns the RAM port whenever load_en is high. The RAM has no
    // reset, so its write enable is gated by resetn to drop writes in reset.
    ram_addr  = load_en ? load_addr : addr[ADDR_W-1:0];
    ram_wdata = load_en ? load_data : dout;
    ram_we    = resetn & (load_en | (wren & (region == RG_RAM)));
    led_we    = ~load_en & wren & (region == RG_LED);

    // Non-RAM read value for this request; an LED write returns the new value.
    aux_next = '0;
    case (region)
      RG_LED:  aux_next = led_we ? DATA_W'(dout[LED_W-1:0]) : DATA_W'(ledr);
      RG_SW:   aux_next = DATA_W'(sw_sync2);
      default: aux_next = '0;
    endcase
  end

  sync_ram_wf #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clock (clock),
    .rd_en (~load_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_q)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sw_sync1    <= '0;
      sw_sync2    <= '0;
      ledr        <= '0;
      src_q       <= RG_NONE;
      aux_q       <= '0;
      rd_valid    <= 1'b0;
      wr_conflict <= 1'b0;
    end else begin
      sw_sync1    <= sw;
      sw_sync2    <= sw_sync1;
      rd_valid    <= ~load_en;
      wr_conflict <= load_en & wren;
      if (led_we) begin
        ledr <= dout[LED_W-1:0];
      end
      // Source select and aux value only move on serviced cycles so din
      // holds through a bootload stall (the RAM output register holds too).
      if (!load_en) begin
        src_q <= region;
        aux_q <= aux_next;
      end
    end
  end

  // Both mux inputs are registers; the reset value of src_q/aux_q forces
  // din to zero asynchronously.
  assign din = (src_q == RG_RAM) ? ram_q : aux_q;

endmodule

// File: tb/tb_proc_mem_responder.sv
module tb_proc_mem_responder;

  localparam int ADDR_W = 8;
  localparam int LED_W  = 10;
  localparam int SW_W   = 10;

  // ---------------- clock / reset ----------------
  logic              clock;
  logic              resetn;
  logic [15:0]       addr;
  logic [15:0]       dout;
  logic              wren;
  logic [15:0]       din;
  logic              rd_valid;
  logic [SW_W-1:0]   sw;
  logic [LED_W-1:0]  ledr;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [15:0]       load_data;
  logic              wr_conflict;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  proc_mem_responder #(
    .ADDR_W (ADDR_W),
    .LED_W  (LED_W),
    .SW_W   (SW_W)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .addr        (addr),
    .dout        (dout),
    .wren        (wren),
    .din         (din),
    .rd_valid    (rd_valid),
    .sw          (sw),
    .ledr        (ledr),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .wr_conflict (wr_conflict)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] m_mem [256];
  bit          m_known [256];
  logic [15:0] m_din;
  bit          m_din_known;
  bit          m_valid;
  bit          m_conf;
  logic [9:0]  m_led;
  logic [9:0]  m_s1;
  logic [9:0]  m_s2;
  logic [15:0] m_rv;
  bit          m_rk;
  int          m_a;

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m_din = 16'h0; m_din_known = 1; m_valid = 0; m_conf = 0;
      m_led = 10'h0; m_s1 = 10'h0; m_s2 = 10'h0;
    end else begin
      m_a  = int'(addr % 256);
      m_rk = 1;
      case (addr / 4096)
        0:       begin m_rv = m_mem[m_a]; m_rk = m_known[m_a]; end
        1:       m_rv = {6'b0, m_led};
        3:       m_rv = {6'b0, m_s2};
        default: m_rv = 16'h0;
      endcase
      m_conf  = load_en && wren;
      m_valid = !load_en;
      if (load_en) begin
        m_mem[int'(load_addr)]   = load_data;
        m_known[int'(load_addr)] = 1;
      end else if (wren && (addr / 4096) == 0) begin
        m_mem[m_a] = dout; m_known[m_a] = 1;
        m_din = dout; m_din_known = 1;
      end else if (wren && (addr / 4096) == 1) begin
        m_led = dout[9:0];
        m_din = {6'b0, dout[9:0]}; m_din_known = 1;
      end else begin
        m_din = m_rv; m_din_known = m_rk;
      end
      m_s2 = m_s1;
      m_s1 = sw;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clock) begin
    if (chk_en) begin
      if (m_din_known) check("cmp_din", din, m_din);
      check("cmp_rd_valid", 16'(rd_valid), 16'(m_valid));
      check("cmp_ledr", 16'(ledr), 16'(m_led));
      check("cmp_wr_conflict", 16'(wr_conflict), 16'(m_conf));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic proc(input logic [15:0] a, input logic [15:0] d, input logic w);
    load_en = 0; addr = a; dout = d; wren = w;
    tick();
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    resetn = 0; addr = 0; dout = 0; wren = 0; sw = '0;
    load_en = 0; load_addr = '0; load_data = 0;
    repeat (2) @(posedge clock);
    #2;
    check("rst_din", din, 16'h0000);
    check("rst_rd_valid", 16'(rd_valid), 16'h0);
    check("rst_ledr", 16'(ledr), 16'h0);
    check("rst_wr_conflict", 16'(wr_conflict), 16'h0);
    chk_en = 1;
    resetn = 1;
    tick();

    // Bootload then read back
    load_en = 1; load_addr = 8'h05; load_data = 16'h1234; wren = 0;
    tick();
    check("boot_rd_valid", 16'(rd_valid), 16'h0);
    proc(16'h0005, 16'h0, 0);
    check("boot_read_din", din, 16'h1234);
    check("boot_read_valid", 16'(rd_valid), 16'h1);

    // Write-first RAM, readback, alias
    proc(16'h0010, 16'hBEEF, 1);
    check("wr_first_din", din, 16'hBEEF);
    proc(16'h0010, 16'h0, 0);
    check("rd_0010", din, 16'hBEEF);
    proc(16'h0110, 16'h0, 0);
    check("rd_alias_0110", din, 16'hBEEF);

    // Back-to-back writes, last wins
    proc(16'h0011, 16'h1111, 1);
    proc(16'h0011, 16'h2222, 1);
    proc(16'h0011, 16'h0, 0);
    check("b2b_last_wins", din, 16'h2222);

    // LED write and read
    proc(16'h1000, 16'hFFFF, 1);
    check("led_wr_ledr", 16'(ledr), 16'h03FF);
    check("led_wr_din", din, 16'h03FF);
    proc(16'h1000, 16'h0, 0);
    check("led_rd_din", din, 16'h03FF);

    // Switch synchronizer latency
    proc(16'h3000, 16'h0, 0);
    sw = 10'h2A5;
    tick();
    check("sw_edge1", din, 16'h0000);
    tick();
    check("sw_edge2", din, 16'h0000);
    tick();
    check("sw_edge3", din, 16'h02A5);
    proc(16'h3000, 16'hFFFF, 1);
    check("sw_write_ignored", din, 16'h02A5);
    check("sw_write_ledr", 16'(ledr), 16'h03FF);

    // Bootload/processor write conflict
    proc(16'h0020, 16'hA0A0, 1);
    load_en = 1; load_addr = 8'h21; load_data = 16'h5A5A;
    addr = 16'h0020; dout = 16'h5555; wren = 1;
    tick();
    check("conf_pulse", 16'(wr_conflict), 16'h1);
    check("conf_rd_valid", 16'(rd_valid), 16'h0);
    check("conf_din_hold", din, 16'hA0A0);
    proc(16'h0020, 16'h0, 0);
    check("conf_pulse_end", 16'(wr_conflict), 16'h0);
    check("conf_ram_kept", din, 16'hA0A0);
    proc(16'h0021, 16'h0, 0);
    check("conf_load_data", din, 16'h5A5A);

    // Unmapped region
    proc(16'h0000, 16'h0F0F, 1);
    proc(16'h7000, 16'h0, 0);
    check("unmapped_rd", din, 16'h0000);
    check("unmapped_valid", 16'(rd_valid), 16'h1);
    proc(16'h7000, 16'h1234, 1);
    check("unmapped_wr_din", din, 16'h0000);
    check("unmapped_wr_ledr", 16'(ledr), 16'h03FF);
    proc(16'h0000, 16'h0, 0);
    check("unmapped_wr_ram", din, 16'h0F0F);

    // Asynchronous reset mid-cycle, writes dropped while in reset
    proc(16'h1000, 16'h0, 0);
    #1;
    resetn = 0;
    #1;
    check("async_rst_ledr", 16'(ledr), 16'h0);
    check("async_rst_din", din, 16'h0000);
    addr = 16'h0010; dout = 16'h0000; wren = 1;
    tick();
    tick();
    resetn = 1;
    proc(16'h0010, 16'h0, 0);
    check("rst_write_dropped", din, 16'hBEEF);
    tick();

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/proc_mem_responder.md
Name: proc_mem_responder

Overview:
- Responder side of the processor's memory interface. The control FSM drives address, data-out and write-enable; this block services those requests and returns read data.
- Provides on-chip RAM for instructions and data, a memory-mapped LED register and a synchronized switch port.
- Includes a bootload write port so RAM can be filled while the processor is held with run=0.
- Read latency is fixed at one clock, which the processor's fetch wait state relies on.

Parameters:
- ADDR_W, 8, RAM word-address width; RAM depth is 2^ADDR_W words of 16 bits.
- LED_W, 10, width of the LED register.
- SW_W, 10, width of the switch input.

Ports:
- clock  in  1  single system clock; all state updates on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- addr  in  16  word address from the processor ADDR register.
- dout  in  16  write data from the processor DOUT register.
- wren  in  1  processor write strobe, sampled at the rising edge.
- din  out  16  registered read data returned to the processor bus.
- rd_valid  out  1  high for the cycle in which din holds data for the address sampled at the previous edge.
- sw  in  SW_W  raw asynchronous switch inputs.
- ledr  out  LED_W  LED register.
- load_en  in  1  bootload write strobe.
- load_addr  in  ADDR_W  bootload RAM address.
- load_data  in  16  bootload write data.
- wr_conflict  out  1  one-cycle pulse when a processor write is dropped because load_en was active.

Behaviour:
- Reset (resetn=0, asynchronous): din=0, rd_valid=0, ledr=0, wr_conflict=0, both switch synchronizer stages=0. RAM contents are not reset. All writes are dropped while resetn=0.
- Region decode on addr[15:12]:
  - 4'h0: RAM, indexed by addr[ADDR_W-1:0]. Bits [11:ADDR_W] are ignored, so the RAM aliases across the region.
  - 4'h1: LED register.
  - 4'h3: switches.
  - Any other value: unmapped.
- Processor read (load_en=0, wren=0): at edge N, din is loaded with the selected source for addr; rd_valid=1 during cycle N+1.
  - RAM region: RAM[addr].
  - LED region: {zero-extend, ledr}.
  - Switch region: {zero-extend, sw_sync2}.
  - Unmapped region: 16'h0000.
- Processor write (load_en=0, wren=1):
  - RAM region: RAM[addr] <= dout. Write-first: din <= dout in the same edge.
  - LED region: ledr <= dout[LED_W-1:0]; din <= zero-extended new ledr value.
  - Switch or unmapped region: write ignored; din <= region read value.
  - rd_valid=1 in the following cycle in all cases.
- Bootload (load_en=1): RAM[load_addr] <= load_data. The processor path is blocked that cycle: din holds its value, rd_valid=0 next cycle, ledr unchanged.
  - If wren=1 in the same cycle, the processor write is dropped and wr_conflict=1 for the next cycle only.
- Switch synchronizer: two flops, sw -> sw_sync1 -> sw_sync2. A sw change becomes visible on din at most 3 edges after it is stable (2 sync edges plus 1 read edge).
- Consecutive writes to the same RAM address in back-to-back cycles: the last write wins. A read in the following cycle returns it.
- There is no request/acknowledge handshake. Latency is always exactly 1 edge, and there are no stall cycles except bootload.

Decomposition:
- Package proc_mem_pkg holds:
  - DATA_W=16;
  - region codes REG_RAM=4'h0, REG_LED=4'h1, REG_SW=4'h3;
  - a region_t enum produced by the decoder.
- Sub-module sync_ram_wf: single-port, write-first RAM with registered read, parameterized by ADDR_W. Bootload and processor writes are muxed before it, with load_en having priority.
- Decode, LED register, switch synchronizer and din mux live in the top module.

Test Plan:
- Reset with RAM preloaded by bootload (load_en=1, load_addr=0x05, load_data=0x1234), release load_en, addr=0x0005, wren=0 -> after one edge din=0x1234 and rd_valid=1.
- Processor write addr=0x0010, dout=0xBEEF, wren=1 -> same edge din=0xBEEF; the next read of 0x0010 returns 0xBEEF. A read of alias 0x0110 (ADDR_W=8) also returns 0xBEEF.
- Write addr=0x1000, dout=0xFFFF -> ledr=10'h3FF and din=0x03FF. Then assert resetn=0 mid-cycle -> ledr=0 and din=0 immediately, without waiting for a clock edge.
- sw=10'h2A5 applied with addr=0x3000 held -> din=0x02A5 no later than the third edge, and not before the second edge.
- load_en=1 with wren=1, addr=0x0020, dout=0x5555 -> RAM[0x20] unchanged by the processor write, wr_conflict=1 for exactly one cycle, rd_valid=0.
- Read of unmapped addr=0x7000 -> din=0x0000 and rd_valid=1. A write to 0x7000 changes neither RAM nor ledr.
